mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_arbiter_rr_pick.sv | 54 +++++
 rtl/mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the data-memory arbiter.
//   arb_state_e : arbiter FSM states
//   log2c()     : ceil(log2(n)), never less than 1, used to size owner/ptr/cnt
//   MAX_NREQ    : largest supported requester count
//   MAX_RD_LAT  : largest supported memory read latency
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int MAX_NREQ   = 8;
  localparam int MAX_RD_LAT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  function automatic int log2c(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational winner select for the memory arbiter. Searches req_i starting
// at index ptr_i and wrapping; the first requester found wins.
// With MEM_ARB_FIXED_PRIO_EN defined the search always starts at index 0
// (lowest index wins) and ptr_i is ignored.
//
// Ports:
//   req_i  [NREQ]  request vector
//   ptr_i  [IW]    search start index
//   gnt_o  [NREQ]  one-hot winner
//   idx_o  [IW]    winner index (0 when none)
//   any_o          at least one request present
// -----------------------------------------------------------------------------
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int IW  = log2c(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  logic [IW-1:0] cand;

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;
`endif

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      cand = IW'(i);
`else
      cand = IW'((int'(ptr_i) + i) % NREQ);
`endif
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port synchronous data memory between NREQ bus masters.
// One transaction is in flight at a time: a request is accepted in IDLE,
// its fields are latched into the memory-side registers, the memory is
// accessed in ISSUE, reads wait out RD_LAT and return data with a
// one-cycle rvalid pulse to the master that issued them.
//
// Optional feature macro: MEM_ARB_FIXED_PRIO_EN
//   undefined : round-robin arbitration (search from ptr, wrap)
//   defined   : fixed priority, lowest index wins, no ptr register
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous reset, active-high
//   req_i        [NREQ]     request per master (held until its gnt)
//   we_i         [NREQ]     1 = write, 0 = read
//   addr_i       [NREQ*AW]  packed addresses, master i at [i*AW +: AW]
//   wdata_i      [NREQ*DW]  packed write data, master i at [i*DW +: DW]
//   gnt_o        [NREQ]     one-hot acceptance pulse (IDLE only, combinational)
//   rvalid_o     [NREQ]     one-hot read-data-valid pulse
//   rdata_o      [DW]       read data, valid with any rvalid bit
//   busy_o                  high whenever the FSM is not in IDLE
//   mem_addr_o   [AW]       registered memory address
//   mem_wdata_o  [DW]       registered memory write data
//   mem_we_o                registered memory write enable
//   mem_rdata_i  [DW]       memory read data
//
// Supported ranges: NREQ 2..MAX_NREQ, RD_LAT 1..MAX_RD_LAT.
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    we_i,
  input  logic [NREQ*AW-1:0] addr_i,
  input  logic [NREQ*DW-1:0] wdata_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic [NREQ-1:0]    rvalid_o,
  output logic [DW-1:0]      rdata_o,
  output logic               busy_o,
  output logic [AW-1:0]      mem_addr_o,
  output logic [DW-1:0]      mem_wdata_o,
  output logic               mem_we_o,
  input  logic [DW-1:0]      mem_rdata_i
);

  localparam int IW = log2c(NREQ);
  localparam int CW = log2c(MAX_RD_LAT);

  arb_state_e    state_q;
  logic [IW-1:0] owner_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          mem_we_q;
  logic [DW-1:0] rdata_q;

  logic [IW-1:0]   ptr_cur;
  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_we;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign ptr_cur = '0;
`else
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;

  assign ptr_cur = ptr_q;
  assign ptr_d   = (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (state_q == IDLE && pick_any) begin
      ptr_q <= ptr_d;
    end
  end
`endif

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req_i (req_i),
    .ptr_i (ptr_cur),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Mux the winning master's request fields onto the latch inputs.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) begin
        sel_addr  = addr_i[i*AW +: AW];
        sel_wdata = wdata_i[i*DW +: DW];
        sel_we    = we_i[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          mem_we_q <= 1'b0;
          if (pick_any) begin
            owner_q     <= pick_idx;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            mem_we_q    <= sel_we;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          // mem_we_q still holds the latched direction of this transaction.
          mem_we_q <= 1'b0;
          if (mem_we_q) begin
            state_q <= IDLE;
          end else begin
            cnt_q   <= CW'(RD_LAT - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            rdata_q <= mem_rdata_i;
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Grant and rvalid are suppressed during reset so an aborted cycle never
  // hands out an acceptance or a response.
  assign gnt_o = (state_q == IDLE && !rst_i) ? pick_gnt : '0;

  always_comb begin
    rvalid_o = '0;
    if (state_q == RESP && !rst_i) begin
      rvalid_o[owner_q] = 1'b1;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign rdata_o     = rdata_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_we_o    = mem_we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with a simple synchronous memory model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int NREQ   = 2;
  localparam int AW     = 16;
  localparam int DW     = 16;
  localparam int RD_LAT = 1;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic               busy;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic               mem_we;
  logic [DW-1:0]      mem_rdata;

  logic               bd_we;
  logic [AW-1:0]      bd_addr;
  logic [DW-1:0]      bd_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .NREQ   (NREQ),
    .AW     (AW),
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .we_i        (we),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .busy_o      (busy),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_we_o    (mem_we),
    .mem_rdata_i (mem_rdata)
  );

  // Memory: address sampled at the edge, data valid RD_LAT cycles later.
  logic [DW-1:0] mem     [0:65535];
  logic [DW-1:0] rd_pipe [0:RD_LAT-1];

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    rd_pipe[0] <= mem[mem_addr];
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NREQ-1:0] onehot(input int m);
    logic [NREQ-1:0] r;
    r    = '0;
    r[m] = 1'b1;
    return r;
  endfunction

  // Single-master transaction, started at a drive point with the DUT in IDLE.
  task automatic do_txn(input string nm, input int m, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] exp);
    req              = '0;
    req[m]           = 1'b1;
    we[m]            = w;
    addr[m*AW +: AW]  = a;
    wdata[m*DW +: DW] = d;
    @(negedge clk);
    chk({nm, "_gnt"}, 32'(gnt), 32'(onehot(m)));
    chk({nm, "_busy0"}, 32'(busy), 32'd0);
    next_cyc();
    // Scramble request fields: the transaction must use the latched copy.
    req   = '0;
    we    = ~we;
    addr  = ~addr;
    wdata = ~wdata;
    @(negedge clk);
    chk({nm, "_issue_we"}, 32'(mem_we), 32'(w));
    chk({nm, "_issue_addr"}, 32'(mem_addr), 32'(a));
    if (w) chk({nm, "_issue_wdata"}, 32'(mem_wdata), 32'(d));
    chk({nm, "_issue_busy"}, 32'(busy), 32'd1);
    chk({nm, "_issue_gnt"}, 32'(gnt), 32'd0);
    next_cyc();
    if (w) begin
      @(negedge clk);
      chk({nm, "_wr_done_we"}, 32'(mem_we), 32'd0);
      chk({nm, "_wr_done_busy"}, 32'(busy), 32'd0);
      chk({nm, "_wr_no_rvalid"}, 32'(rvalid), 32'd0);
      next_cyc();
    end else begin
      for (int c = 0; c < RD_LAT; c++) begin
        @(negedge clk);
        chk({nm, "_wait_rvalid"}, 32'(rvalid), 32'd0);
        chk({nm, "_wait_busy"}, 32'(busy), 32'd1);
        chk({nm, "_wait_we"}, 32'(mem_we), 32'd0);
        next_cyc();
      end
      @(negedge clk);
      chk({nm, "_rvalid"}, 32'(rvalid), 32'(onehot(m)));
      chk({nm, "_rdata"}, 32'(rdata), 32'(exp));
      chk({nm, "_resp_busy"}, 32'(busy), 32'd1);
      next_cyc();
      @(negedge clk);
      chk({nm, "_rvalid_pulse"}, 32'(rvalid), 32'd0);
      chk({nm, "_post_busy"}, 32'(busy), 32'd0);
      chk({nm, "_rdata_hold"}, 32'(rdata), 32'(exp));
      next_cyc();
    end
  endtask

  typedef struct {
    int              m;
    logic            w;
    logic [AW-1:0]   a;
    logic [DW-1:0]   d;
    logic [DW-1:0]   exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [NREQ-1:0] exp_order [4];
    logic [DW-1:0]   exp_rd    [NREQ];
    int              ngnt;
    int              nresp;
    int              last;
    bit              drop;

    vecs[0] = '{0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000};
    vecs[1] = '{0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vecs[2] = '{1, 1'b0, 16'h0020, 16'h0000, 16'h1234};
    vecs[3] = '{1, 1'b1, 16'h0050, 16'hCAFE, 16'h0000};
    vecs[4] = '{0, 1'b0, 16'h0050, 16'h0000, 16'hCAFE};
    vecs[5] = '{1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vecs[6] = '{0, 1'b1, 16'hFFFF, 16'h0001, 16'h0000};
    vecs[7] = '{1, 1'b0, 16'hFFFF, 16'h0000, 16'h0001};

    rst   = 1'b1;
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    bd_we = 1'b1;

    // Preload memory through the backdoor while in reset.
    bd_addr = 16'h0020; bd_data = 16'h1234; next_cyc();
    bd_addr = 16'h0030; bd_data = 16'hAAAA; next_cyc();
    bd_addr = 16'h0040; bd_data = 16'h5555; next_cyc();
    bd_we = 1'b0;
    next_cyc();
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_gnt", 32'(gnt), 32'd0);
      chk("idle_mem_we", 32'(mem_we), 32'd0);
      chk("idle_rvalid", 32'(rvalid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_mem_addr", 32'(mem_addr), 32'h0000);
      chk("idle_rdata", 32'(rdata), 32'h0000);
      next_cyc();
    end

    for (int i = 0; i < 8; i++) begin
      do_txn($sformatf("v%0d", i), vecs[i].m, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp);
    end

    // Address changes right after the grant; the latched 0x0030 must be used.
    req     = 2'b01;
    we      = 2'b00;
    addr[0 +: AW] = 16'h0030;
    @(negedge clk);
    chk("latch_gnt", 32'(gnt), 32'h1);
    next_cyc();
    req     = '0;
    addr[0 +: AW] = 16'h0040;
    @(negedge clk);
    chk("latch_mem_addr", 32'(mem_addr), 32'h0030);
    next_cyc();
    for (int c = 0; c < RD_LAT; c++) next_cyc();
    @(negedge clk);
    chk("latch_rvalid", 32'(rvalid), 32'h1);
    chk("latch_rdata", 32'(rdata), 32'hAAAA);
    next_cyc();

    // Both masters requesting reads continuously; pointer starts at 0.
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp_order = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    exp_rd[0] = 16'hBEEF;
    exp_rd[1] = 16'h1234;
    req   = 2'b11;
    we    = 2'b00;
    addr  = {16'h0020, 16'h0010};
    ngnt  = 0;
    nresp = 0;
    last  = 0;
    drop  = 1'b0;
    for (int cyc = 0; cyc < 40 && nresp < 4; cyc++) begin
      @(negedge clk);
      if (gnt != '0) begin
        chk($sformatf("multi_gnt_onehot%0d", ngnt), 32'($countones(gnt)), 32'd1);
        if (ngnt < 4) chk($sformatf("multi_gnt_order%0d", ngnt), 32'(gnt), 32'(exp_order[ngnt]));
        last = gnt[1] ? 1 : 0;
        ngnt++;
        if (ngnt == 4) drop = 1'b1;
      end
      if (rvalid != '0) begin
        chk($sformatf("multi_rvalid%0d", nresp), 32'(rvalid), 32'(onehot(last)));
        chk($sformatf("multi_rdata%0d", nresp), 32'(rdata), 32'(exp_rd[last]));
        nresp++;
      end
      next_cyc();
      if (drop) req = '0;
    end
    chk("multi_grant_count", 32'(ngnt), 32'd4);
    chk("multi_resp_count", 32'(nresp), 32'd4);
    req = '0;
    next_cyc();

    // Reset lands while a read is in WAIT.
    req = 2'b10;
    we  = 2'b00;
    addr[AW +: AW] = 16'h0020;
    @(negedge clk);
    chk("abort_gnt", 32'(gnt), 32'h2);
    next_cyc();
    req = '0;
    next_cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("abort_wait_busy", 32'(busy), 32'd1);
    chk("abort_wait_rvalid", 32'(rvalid), 32'd0);
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle_busy", 32'(busy), 32'd0);
    chk("abort_idle_we", 32'(mem_we), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("abort_no_rvalid", 32'(rvalid), 32'd0);
      next_cyc();
    end
    do_txn("after_abort", 0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
